// File: rtl/reg_file_scoreboard.sv
// Register file with two combinational read ports, one writeback port and a
// per-register 2-bit pending-write scoreboard that gates instruction issue.
module reg_file_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              use_rs,
    input  logic              use_rt,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              stall,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              pend_err
);

    localparam int NREG = 2 ** ADDR_W;
    localparam bit BYP_EN = (BYPASS != 32'sd0);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [1:0]        cnt_q [NREG];
    logic [1:0]        cnt_d [NREG];
    logic              pend_err_q;
    logic              pend_err_d;

    logic              wb_act_s;
    logic              busy_rs_s;
    logic              busy_rt_s;
    logic              dst_full_s;
    logic              stall_s;
    logic              inc_s;
    logic              dec_s;
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;

    // A source is busy while writes are outstanding, unless the last one is
    // retiring this very cycle and its data can be forwarded.
    function automatic logic busy_f(input logic [ADDR_W-1:0] addr,
                                    input logic [1:0]        cnt,
                                    input logic              wb_hit);
        logic busy;
        if (addr == ZERO_ADDR) begin
            busy = 1'b0;
        end else if (cnt == 2'd0) begin
            busy = 1'b0;
        end else if (BYP_EN && (cnt == 2'd1) && wb_hit) begin
            busy = 1'b0;
        end else begin
            busy = 1'b1;
        end
        return busy;
    endfunction

    // Read ports with optional same-cycle writeback forwarding
    always_comb begin
        wb_act_s = wb_en && (wb_addr != ZERO_ADDR);
        if (rs_addr == ZERO_ADDR) begin
            rs_data_s = ZERO_DATA;
        end else if (BYP_EN && wb_act_s && (wb_addr == rs_addr)) begin
            rs_data_s = wb_data;
        end else begin
            rs_data_s = mem_q[rs_addr];
        end
        if (rt_addr == ZERO_ADDR) begin
            rt_data_s = ZERO_DATA;
        end else if (BYP_EN && wb_act_s && (wb_addr == rt_addr)) begin
            rt_data_s = wb_data;
        end else begin
            rt_data_s = mem_q[rt_addr];
        end
    end

    // Issue hazard detection: RAW on either source, or destination counter full
    always_comb begin
        busy_rs_s  = busy_f(rs_addr, cnt_q[rs_addr], wb_act_s && (wb_addr == rs_addr));
        busy_rt_s  = busy_f(rt_addr, cnt_q[rt_addr], wb_act_s && (wb_addr == rt_addr));
        dst_full_s = (issue_dst != ZERO_ADDR) && (cnt_q[issue_dst] == 2'd3)
                     && !(wb_en && (wb_addr == issue_dst));
        stall_s    = issue_valid && ((use_rs && busy_rs_s) || (use_rt && busy_rt_s) || dst_full_s);
        inc_s      = issue_valid && !stall_s && (issue_dst != ZERO_ADDR);
        dec_s      = wb_act_s && (cnt_q[wb_addr] != 2'd0);
    end

    // Next state for the array, scoreboard counters and sticky error flag
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if ((r != 0) && wb_act_s && (wb_addr == ADDR_W'(r))) begin
                mem_d[r] = wb_data;
            end else begin
                mem_d[r] = mem_q[r];
            end
            case ({inc_s && (issue_dst == ADDR_W'(r)), dec_s && (wb_addr == ADDR_W'(r))})
                2'b10:   cnt_d[r] = (cnt_q[r] == 2'd3) ? 2'd3 : cnt_q[r] + 2'd1;
                2'b01:   cnt_d[r] = cnt_q[r] - 2'd1;
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
        if (wb_act_s && (cnt_q[wb_addr] == 2'd0)) begin
            pend_err_d = 1'b1;
        end else begin
            pend_err_d = pend_err_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= ZERO_DATA;
                cnt_q[r] <= 2'd0;
            end
            pend_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= mem_d[r];
                cnt_q[r] <= cnt_d[r];
            end
            pend_err_q <= pend_err_d;
        end
    end

    assign rs_data  = rs_data_s;
    assign rt_data  = rt_data_s;
    assign stall    = stall_s;
    assign pend_err = pend_err_q;

endmodule
